// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame parser: FSM state encoding, default
// framing constants and the running 8-bit checksum.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_HOLD    = 3'd4
    } state_e;

    localparam int         DEFAULT_MAX_PAYLOAD = 16;
    localparam logic [7:0] DEFAULT_SOF_BYTE    = 8'hAA;

    // A frame is good when LEN + payload + CHK sums to zero modulo 256.
    function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: DEPTH x 8 register file with a synchronous write port and a
// registered read port; the array itself is never reset, only the read register.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles SOF/LEN/payload/CHK frames from a UART byte stream and holds good
// payloads for random-access reads. Define UART_FRAME_TIMEOUT_EN to add an
// inter-byte timeout (TIMEOUT_CLKS parameter and o_Timeout_Err port).
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         MAX_PAYLOAD  = DEFAULT_MAX_PAYLOAD,
    parameter logic [7:0] SOF_BYTE     = DEFAULT_SOF_BYTE,
`ifdef UART_FRAME_TIMEOUT_EN
    parameter int         TIMEOUT_CLKS = 43400,
`endif
    localparam int        LW = $clog2(MAX_PAYLOAD + 1),
    localparam int        AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
    input  logic          i_Clock,
    input  logic          i_Reset,
    input  logic          i_Rx_DV,
    input  logic [7:0]    i_Rx_Byte,
    output logic          o_Frame_Valid,
    output logic [LW-1:0] o_Frame_Len,
    input  logic [AW-1:0] i_Rd_Addr,
    output logic [7:0]    o_Rd_Data,
    input  logic          i_Frame_Ack,
    output logic          o_Crc_Err,
    output logic          o_Len_Err,
    output logic          o_Overrun
`ifdef UART_FRAME_TIMEOUT_EN
   ,output logic          o_Timeout_Err
`endif
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    state_e        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    idx_q, idx_d;
    logic          fv_q, fv_d;
    logic [LW-1:0] flen_q, flen_d;
    logic          crc_err_q, crc_err_d;
    logic          len_err_q, len_err_d;
    logic          ovr_q, ovr_d;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_err_q, to_err_d;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        sum_d     = sum_q;
        idx_d     = idx_q;
        fv_d      = fv_q;
        flen_d    = flen_q;
        crc_err_d = 1'b0;
        len_err_d = 1'b0;
        ovr_d     = 1'b0;
        wr_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_Rx_DV && (i_Rx_Byte == SOF_BYTE)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (i_Rx_DV) begin
                    len_d = i_Rx_Byte;
                    sum_d = i_Rx_Byte;
                    idx_d = 8'd0;
                    if ((i_Rx_Byte == 8'd0) || (i_Rx_Byte > MAX_LEN)) begin
                        len_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d   = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (i_Rx_DV) begin
                    wr_en = 1'b1;
                    sum_d = chk_add(sum_q, i_Rx_Byte);
                    idx_d = idx_q + 8'd1;
                    if (idx_d == len_q) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (i_Rx_DV) begin
                    if (chk_add(sum_q, i_Rx_Byte) == 8'h00) begin
                        state_d = ST_HOLD;
                        fv_d    = 1'b1;
                        flen_d  = len_q[LW-1:0];
                    end else begin
                        crc_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                // Bytes are never parsed here, even one that coincides with the ack.
                ovr_d = i_Rx_DV;
                if (i_Frame_Ack) begin
                    state_d = ST_IDLE;
                    fv_d    = 1'b0;
                    flen_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef UART_FRAME_TIMEOUT_EN
        to_cnt_d = '0;
        to_err_d = 1'b0;
        if ((state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK)) begin
            if (i_Rx_DV) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TW'(TIMEOUT_CLKS - 1)) begin
                to_err_d = 1'b1;
                state_d  = ST_IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end
`endif
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            len_q     <= 8'd0;
            sum_q     <= 8'd0;
            idx_q     <= 8'd0;
            fv_q      <= 1'b0;
            flen_q    <= '0;
            crc_err_q <= 1'b0;
            len_err_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            idx_q     <= idx_d;
            fv_q      <= fv_d;
            flen_q    <= flen_d;
            crc_err_q <= crc_err_d;
            len_err_q <= len_err_d;
            ovr_q     <= ovr_d;
        end
    end

`ifdef UART_FRAME_TIMEOUT_EN
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign o_Timeout_Err = to_err_q;
`endif

    assign wr_addr = idx_q[AW-1:0];

    uart_frame_buf #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (AW)
    ) u_buf (
        .clk_i     (i_Clock),
        .rst_i     (i_Reset),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (i_Rx_Byte),
        .rd_addr_i (i_Rd_Addr),
        .rd_data_o (o_Rd_Data)
    );

    assign o_Frame_Valid = fv_q;
    assign o_Frame_Len   = flen_q;
    assign o_Crc_Err     = crc_err_q;
    assign o_Len_Err     = len_err_q;
    assign o_Overrun     = ovr_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: expected frame/error events are queued
// as bytes are driven and matched against DUT pulses by a negedge monitor.
module tb_uart_frame_parser;

    localparam int MAXP = 16;
    localparam int LW   = $clog2(MAXP + 1);
    localparam int AW   = $clog2(MAXP);
`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TO_CLKS = 100;
`endif

    localparam int EV_NONE = 0, EV_FRAME = 1, EV_CRC = 2, EV_LEN = 3, EV_OVR = 4, EV_TO = 5;

    typedef struct {
        int kind;
        int len;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] bq[$];
    logic [7:0] pl[256];
    int         n_tests = 0;
    int         n_fail  = 0;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          rx_dv   = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic [AW-1:0] rd_addr = '0;
    logic          ack     = 1'b0;
    logic          fv;
    logic [LW-1:0] flen;
    logic [7:0]    rd_data;
    logic          crc_err, len_err, ovr;
`ifdef UART_FRAME_TIMEOUT_EN
    logic          to_err;
`endif
    logic          fv_prev = 1'b0;

    always #5 clk = ~clk;

    uart_frame_parser #(
        .MAX_PAYLOAD  (MAXP),
        .SOF_BYTE     (8'hAA)
`ifdef UART_FRAME_TIMEOUT_EN
       ,.TIMEOUT_CLKS (TO_CLKS)
`endif
    ) dut (
        .i_Clock       (clk),
        .i_Reset       (rst),
        .i_Rx_DV       (rx_dv),
        .i_Rx_Byte     (rx_byte),
        .o_Frame_Valid (fv),
        .o_Frame_Len   (flen),
        .i_Rd_Addr     (rd_addr),
        .o_Rd_Data     (rd_data),
        .i_Frame_Ack   (ack),
        .o_Crc_Err     (crc_err),
        .o_Len_Err     (len_err),
        .o_Overrun     (ovr)
`ifdef UART_FRAME_TIMEOUT_EN
       ,.o_Timeout_Err (to_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_event(input int kind, input int len);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_unexpected_event", kind, EV_NONE);
        end else begin
            e = sb_q.pop_front();
            check("sb_kind", kind, e.kind);
            if (kind == EV_FRAME) check("sb_len", len, e.len);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            fv_prev = 1'b0;
        end else begin
            if (crc_err) sb_event(EV_CRC, 0);
            if (len_err) sb_event(EV_LEN, 0);
            if (ovr)     sb_event(EV_OVR, 0);
`ifdef UART_FRAME_TIMEOUT_EN
            if (to_err)  sb_event(EV_TO, 0);
`endif
            if (fv && !fv_prev) sb_event(EV_FRAME, int'(flen));
            fv_prev = fv;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic expect_ev(input int kind, input int len);
        exp_t e;
        e.kind = kind;
        e.len  = len;
        sb_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        tick();
        rx_dv   = 1'b0;
    endtask

    task automatic send_all(input int gap);
        foreach (bq[i]) begin
            send_byte(bq[i]);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic send_frame(input int len, input bit good, input int gap);
        logic [7:0] s;
        s = 8'(len);
        bq.delete();
        bq.push_back(8'hAA);
        bq.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            bq.push_back(pl[i]);
            s = s + pl[i];
        end
        s = 8'h00 - s;
        if (!good) s = s ^ 8'h01;
        bq.push_back(s);
        if (good) expect_ev(EV_FRAME, len);
        else      expect_ev(EV_CRC, 0);
        send_all(gap);
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int w;
        w = 0;
        idle(2);
        while ((sb_q.size() != 0) && (w < max_cycles)) begin
            tick();
            w++;
        end
        check(tag, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic read_chk(input string tag, input int addr, input logic [7:0] exp);
        rd_addr = AW'(addr);
        tick();
        check(tag, rd_data, exp);
    endtask

    task automatic ack_frame(input string tag);
        check({tag, "_fv_held"}, fv, 1'b1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, "_fv_released"}, fv, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fv"}, fv, 1'b0);
        check({tag, "_len"}, flen, '0);
        check({tag, "_rd"}, rd_data, 8'h00);
        check({tag, "_crc"}, crc_err, 1'b0);
        check({tag, "_lenerr"}, len_err, 1'b0);
        check({tag, "_ovr"}, ovr, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle(3);
        check_all_zero("reset");
        rst = 1'b0;
        idle(2);

        // Good frame, reads with one-cycle latency, then overrun during hold
        bq = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        expect_ev(EV_FRAME, 3);
        send_all(0);
        drain("good_frame", 10);
        check("good_fv", fv, 1'b1);
        check("good_len", flen, 3);
        read_chk("good_rd0", 0, 8'h11);
        rd_addr = AW'(1);
        #1;
        check("rd_latency", rd_data, 8'h11);
        tick();
        check("good_rd1", rd_data, 8'h22);
        read_chk("good_rd2", 2, 8'h33);

        for (int i = 0; i < 3; i++) expect_ev(EV_OVR, 0);
        bq = '{8'hAA, 8'h03, 8'h55};
        send_all(1);
        drain("overrun_x3", 10);
        read_chk("ovr_rd0", 0, 8'h11);
        read_chk("ovr_rd1", 1, 8'h22);
        read_chk("ovr_rd2", 2, 8'h33);
        check("ovr_len", flen, 3);

        // Byte coincident with ack is dropped, not taken as SOF
        expect_ev(EV_OVR, 0);
        rx_dv = 1'b1; rx_byte = 8'hAA; ack = 1'b1;
        tick();
        rx_dv = 1'b0; ack = 1'b0;
        check("ackovr_fv", fv, 1'b0);
        drain("ackovr_pulse", 10);
        bq = '{8'hAA, 8'h01, 8'h5A, 8'hA5};
        expect_ev(EV_FRAME, 1);
        send_all(0);
        drain("after_ackovr_frame", 10);
        read_chk("after_ackovr_rd0", 0, 8'h5A);
        ack_frame("ack1");

        // Bad checksum, then a good frame with random payload and gaps
        bq = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
        expect_ev(EV_CRC, 0);
        send_all(0);
        drain("bad_crc", 10);
        check("bad_crc_fv", fv, 1'b0);
        for (int i = 0; i < 5; i++) pl[i] = 8'($urandom);
        send_frame(5, 1'b1, 2);
        drain("post_crc_frame", 10);
        for (int i = 0; i < 5; i++) read_chk($sformatf("post_crc_rd%0d", i), i, pl[i]);
        ack_frame("ack2");

        // Length errors and ignored leading bytes
        bq = '{8'hAA, 8'h00};
        expect_ev(EV_LEN, 0);
        send_all(0);
        drain("len_zero", 10);
        bq = '{8'hAA, 8'h11};
        expect_ev(EV_LEN, 0);
        send_all(0);
        drain("len_17", 10);
        bq = '{8'h55, 8'hFF, 8'hAA, 8'h01, 8'h5A, 8'hA5};
        expect_ev(EV_FRAME, 1);
        send_all(0);
        drain("lead_junk_frame", 10);
        check("lead_junk_len", flen, 1);
        read_chk("lead_junk_rd0", 0, 8'h5A);
        ack_frame("ack3");

        // SOF value inside the frame is plain data
        pl[0] = 8'hAA; pl[1] = 8'hAA; pl[2] = 8'h07;
        send_frame(3, 1'b1, 0);
        drain("sof_as_data", 10);
        read_chk("sof_data_rd1", 1, 8'hAA);
        read_chk("sof_data_rd2", 2, 8'h07);
        ack_frame("ack4");

        // Maximum length frame
        for (int i = 0; i < MAXP; i++) pl[i] = 8'($urandom);
        send_frame(MAXP, 1'b1, 0);
        drain("max_len_frame", 10);
        check("max_len", flen, MAXP);
        for (int i = 0; i < MAXP; i++) read_chk($sformatf("max_rd%0d", i), i, pl[i]);
        ack_frame("ack5");

        // Reset mid-payload, then a clean frame
        bq = '{8'hAA, 8'h04, 8'h01};
        send_all(0);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        tick();
        rst = 1'b0;
        idle(1);
        pl[0] = 8'hC3; pl[1] = 8'h3C;
        send_frame(2, 1'b1, 0);
        drain("post_rst_frame", 10);
        read_chk("post_rst_rd0", 0, 8'hC3);
        read_chk("post_rst_rd1", 1, 8'h3C);

        // Reset while holding drops valid without a clock edge
        #3;
        rst = 1'b1;
        #1;
        check("hold_rst_fv", fv, 1'b0);
        tick();
        rst = 1'b0;
        idle(1);

        // Bad checksum on a random frame
        for (int i = 0; i < 4; i++) pl[i] = 8'($urandom);
        send_frame(4, 1'b0, 0);
        drain("rand_bad_crc", 10);

`ifdef UART_FRAME_TIMEOUT_EN
        bq = '{8'hAA, 8'h02, 8'h01};
        expect_ev(EV_TO, 0);
        send_all(0);
        drain("timeout_pulse", TO_CLKS + 20);
        bq = '{8'hAA, 8'h01, 8'h5A, 8'hA5};
        expect_ev(EV_FRAME, 1);
        send_all(0);
        drain("post_timeout_frame", 10);
        ack_frame("ack_to");
        pl[0] = 8'h01; pl[1] = 8'h02;
        send_frame(2, 1'b1, TO_CLKS - 2);
        drain("spaced_no_timeout", 10);
        read_chk("spaced_rd1", 1, 8'h02);
        ack_frame("ack_spaced");
`endif

        idle(5);
        check("sb_empty_end", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
